alu_exec_unit: RTL and testbench

//   Parametrised integer execute unit for the MIPS datapath. Successor to the

---
 rtl/alu_exec_if.sv | 28 ++
 rtl/alu_exec_unit.sv | 129 ++++++++++++
 tb/tb_alu_exec_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between decode, the execute unit and writeback.
// master drives operands and consumes results; slave is the execute unit.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [IMM_W-1:0] immediate;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, opcode, a, b, immediate, out_ready,
    input  in_ready, out_valid, result, overflow, illegal
  );

  modport slave (
    input  in_valid, opcode, a, b, immediate, out_ready,
    output in_ready, out_valid, result, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle add/sub/address ops and an iterative
// shift-add unsigned multiply, with valid/ready on both sides.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_exec_if.slave   io_alu
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_result, w_result_d;
  logic               r_overflow, w_overflow_d;
  logic               r_illegal, w_illegal_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic [2*WIDTH-1:0] r_acc, w_acc_d;
  logic [2*WIDTH-1:0] r_mcand, w_mcand_d;
  logic [WIDTH-1:0]   r_mplier, w_mplier_d;

  logic               w_accept;
  logic [WIDTH-1:0]   w_imm_ext;
  logic [WIDTH-1:0]   w_opb;
  logic               w_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_sum_ovf;
  logic [2*WIDTH-1:0] w_acc_add;

  assign io_alu.in_ready  = (r_state == StIdle) | ((r_state == StDone) & io_alu.out_ready);
  assign io_alu.out_valid = (r_state == StDone);
  assign io_alu.result    = r_result;
  assign io_alu.overflow  = r_overflow;
  assign io_alu.illegal   = r_illegal;

  assign w_accept  = io_alu.in_valid & io_alu.in_ready;
  assign w_imm_ext = {{(WIDTH-IMM_W){io_alu.immediate[IMM_W-1]}}, io_alu.immediate};

  // SUB is a + ~b + 1, so the same-sign overflow test applies to the inverted operand.
  always_comb begin
    w_opb = io_alu.b;
    w_cin = 1'b0;
    unique case (io_alu.opcode)
      3'b001, 3'b010, 3'b011: w_opb = w_imm_ext;
      3'b100: begin
        w_opb = ~io_alu.b;
        w_cin = 1'b1;
      end
      default: w_opb = io_alu.b;
    endcase
  end

  assign w_sum     = io_alu.a + w_opb + {{(WIDTH-1){1'b0}}, w_cin};
  assign w_sum_ovf = (io_alu.a[WIDTH-1] == w_opb[WIDTH-1]) & (w_sum[WIDTH-1] != io_alu.a[WIDTH-1]);
  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_state_d    = r_state;
    w_result_d   = r_result;
    w_overflow_d = r_overflow;
    w_illegal_d  = r_illegal;
    w_cnt_d      = r_cnt;
    w_acc_d      = r_acc;
    w_mcand_d    = r_mcand;
    w_mplier_d   = r_mplier;

    if (w_accept) begin
      w_overflow_d = 1'b0;
      w_illegal_d  = 1'b0;
      w_state_d    = StDone;
      unique case (io_alu.opcode)
        3'b000, 3'b001, 3'b100: begin
          w_result_d   = w_sum;
          w_overflow_d = w_sum_ovf;
        end
        3'b010, 3'b011: w_result_d = w_sum;
        3'b101: begin
          w_state_d  = StMul;
          w_cnt_d    = '0;
          w_acc_d    = '0;
          w_mcand_d  = {{WIDTH{1'b0}}, io_alu.a};
          w_mplier_d = io_alu.b;
        end
        default: begin
          w_result_d  = '0;
          w_illegal_d = 1'b1;
        end
      endcase
    end else if (r_state == StDone && io_alu.out_ready) begin
      w_state_d = StIdle;
    end else if (r_state == StMul) begin
      w_acc_d    = w_acc_add;
      w_mcand_d  = r_mcand << 1;
      w_mplier_d = r_mplier >> 1;
      w_cnt_d    = r_cnt + 1'b1;
      if (r_cnt == LastCnt) begin
        w_state_d    = StDone;
        w_cnt_d      = '0;
        w_result_d   = w_acc_add[WIDTH-1:0];
        w_overflow_d = |w_acc_add[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_result   <= w_result_d;
      r_overflow <= w_overflow_d;
      r_illegal  <= w_illegal_d;
      r_cnt      <= w_cnt_d;
      r_acc      <= w_acc_d;
      r_mcand    <= w_mcand_d;
      r_mplier   <= w_mplier_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, checked 1 time unit
// after each rising edge.
module tb_alu_exec_unit;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IMM_W = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_exec_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_alu (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm);
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.a         = a;
    bus.b         = b;
    bus.immediate = imm;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.immediate = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst result", 64'(bus.result), 64'd0);
    check("rst flags", {62'd0, bus.overflow, bus.illegal}, 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD with positive overflow
    drive(3'b000, 32'h7FFF_FFFF, 32'h1, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    check("add ovf valid", 64'(bus.out_valid), 64'd1);
    check("add ovf result", 64'(bus.result), 64'h8000_0000);
    check("add ovf flag", 64'(bus.overflow), 64'd1);
    tick();
    check("idle out_valid", 64'(bus.out_valid), 64'd0);
    check("idle in_ready", 64'(bus.in_ready), 64'd1);

    // ADDI negative immediate is sign-extended
    drive(3'b001, 32'h100, 32'h0, 16'hFFFC);
    tick();
    bus.in_valid = 1'b0;
    check("addi result", 64'(bus.result), 64'h0000_00FC);
    check("addi ovf", 64'(bus.overflow), 64'd0);
    tick();

    // LW address: signed overflow is masked
    drive(3'b010, 32'h7FFF_FFFF, 32'h0, 16'h0001);
    tick();
    bus.in_valid = 1'b0;
    check("lw result", 64'(bus.result), 64'h8000_0000);
    check("lw ovf", 64'(bus.overflow), 64'd0);
    tick();

    // SUB negative overflow
    drive(3'b100, 32'h8000_0000, 32'h1, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    check("sub ovf result", 64'(bus.result), 64'h7FFF_FFFF);
    check("sub ovf flag", 64'(bus.overflow), 64'd1);
    tick();

    // MULT 0x1234*0x5678, in_valid asserted throughout MUL must be ignored
    drive(3'b101, 32'h1234, 32'h5678, 16'h0);
    tick();
    drive(3'b000, 32'h1, 32'h1, 16'h0);
    for (int i = 0; i < 32; i++) begin
      check("mul busy", {62'd0, bus.in_ready, bus.out_valid}, 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("mul1 valid", 64'(bus.out_valid), 64'd1);
    check("mul1 result", 64'(bus.result), 64'h0626_0060);
    check("mul1 ovf", 64'(bus.overflow), 64'd0);
    tick();

    // MULT 0x10000*0x10000: low half zero, high half nonzero; then stall in DONE
    bus.out_ready = 1'b0;
    drive(3'b101, 32'h0001_0000, 32'h0001_0000, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    check("mul2 not yet", 64'(bus.out_valid), 64'd0);
    tick();
    check("mul2 valid", 64'(bus.out_valid), 64'd1);
    check("mul2 result", 64'(bus.result), 64'd0);
    check("mul2 ovf", 64'(bus.overflow), 64'd1);
    drive(3'b100, 32'd5, 32'd7, 16'h0);
    for (int i = 0; i < 5; i++) begin
      check("stall in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      check("stall held", {bus.out_valid, bus.overflow, bus.result}, {1'b1, 1'b1, 32'd0});
    end
    bus.out_ready = 1'b1;
    #1;
    check("release in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("b2b sub valid", 64'(bus.out_valid), 64'd1);
    check("b2b sub result", 64'(bus.result), 64'hFFFF_FFFE);
    check("b2b sub ovf", 64'(bus.overflow), 64'd0);
    tick();
    check("b2b no dup", 64'(bus.out_valid), 64'd0);

    // Illegal opcode, then back-to-back ADD clears the flag
    drive(3'b111, 32'h55, 32'h66, 16'h0);
    tick();
    check("ill result", 64'(bus.result), 64'd0);
    check("ill flag", 64'(bus.illegal), 64'd1);
    drive(3'b000, 32'd2, 32'd3, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    check("post-ill result", 64'(bus.result), 64'd5);
    check("post-ill flag", 64'(bus.illegal), 64'd0);
    tick();

    // Reset asserted mid-MUL aborts the operation
    drive(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort result", 64'(bus.result), 64'd0);
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst idle", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
